dsp_mac_modes: RTL and testbench

DSP_MAC_MODES -- requirements
Module: dsp_mac_modes

---
 rtl/dsp_mac_pkg.sv | 47 ++++
 rtl/dsp_pipe_reg.sv | 41 ++++
 rtl/dsp_mac_modes.sv | 166 ++++++++++++++++
 tb/tb_dsp_mac_modes.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dsp_mac_pkg                                                       |
// | Brief  : Mode names and mode-to-pipeline helpers for dsp_mac_modes         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package dsp_mac_pkg;

  localparam string MODE_NONE    = "REGISTERED_NONE";
  localparam string MODE_IN      = "REGISTERED_IN";
  localparam string MODE_OUT     = "REGISTERED_OUT";
  localparam string MODE_INOUT   = "REGISTERED_INOUT";
  localparam string MODE_PARTIAL = "REGISTERED_PARTIAL";
  localparam string MODE_FULL    = "REGISTERED_FULL";

  // Bit positions inside the stage-enable vector
  localparam int STG_IN  = 2;
  localparam int STG_MID = 1;
  localparam int STG_OUT = 0;

  // Stage enables {IN, MID, OUT}; unknown names map to all-bypass
  function automatic logic [2:0] mode_stages(input string mode);
    logic [2:0] stages;
    stages = 3'b000;
    if (mode == MODE_IN)           stages = 3'b100;
    else if (mode == MODE_OUT)     stages = 3'b001;
    else if (mode == MODE_INOUT)   stages = 3'b101;
    else if (mode == MODE_PARTIAL) stages = 3'b010;
    else if (mode == MODE_FULL)    stages = 3'b111;
    return stages;
  endfunction

  function automatic bit mode_is_valid(input string mode);
    return (mode == MODE_NONE)  || (mode == MODE_IN)      ||
           (mode == MODE_OUT)   || (mode == MODE_INOUT)   ||
           (mode == MODE_PARTIAL) || (mode == MODE_FULL);
  endfunction

  // Input-to-output latency equals the number of enabled stages
  function automatic int mode_latency(input string mode);
    logic [2:0] stages;
    stages = mode_stages(mode);
    return int'(stages[STG_IN]) + int'(stages[STG_MID]) + int'(stages[STG_OUT]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dsp_pipe_reg                                                      |
// | Brief  : Optional pipeline register with clock enable, or a plain wire     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module dsp_pipe_reg #(
  parameter int WIDTH  = 1,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (BYPASS) begin : g_bypass
      // Clock, reset and enable have no effect on a bypassed stage
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, ce};
      assign q = d;
    end else begin : g_reg
      logic [WIDTH-1:0] data_q;

      // Capture on enabled edges; async clear discards in-flight data
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (ce) begin
          data_q <= d;
        end
      end

      assign q = data_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dsp_mac_modes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dsp_mac_modes                                                     |
// | Brief  : Multiply-accumulate with selectable IN/MID/OUT register stages,   |
// |          clock enable and sticky accumulation-overflow flag               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module dsp_mac_modes
  import dsp_mac_pkg::*;
#(
  parameter int    A_WIDTH   = 2,
  parameter int    B_WIDTH   = 2,
  parameter int    OUT_WIDTH = 8,
  parameter int    SIGNED    = 0,
  parameter string MODE      = "REGISTERED_INOUT"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 m,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 ovf
);

  localparam logic [2:0] STAGES  = mode_stages(MODE);
  localparam bit         HAS_IN  = STAGES[STG_IN];
  localparam bit         HAS_MID = STAGES[STG_MID];
  localparam bit         HAS_OUT = STAGES[STG_OUT];
  localparam int         PW      = A_WIDTH + B_WIDTH;
  localparam int         IN_W    = 2 + A_WIDTH + B_WIDTH;
  localparam int         MID_W   = 2 + OUT_WIDTH;

  generate
    if (!mode_is_valid(MODE)) begin : g_bad_mode
      $error("dsp_mac_modes: unsupported MODE %s", MODE);
    end
    if (OUT_WIDTH < PW) begin : g_bad_width
      $error("dsp_mac_modes: OUT_WIDTH must be at least A_WIDTH+B_WIDTH");
    end
  endgenerate

  // ---------------- IN stage: {valid, m, a, b} ----------------
  logic [IN_W-1:0]    w_in_d;
  logic [IN_W-1:0]    w_in_q;
  logic               w_v1;
  logic               w_m1;
  logic [A_WIDTH-1:0] w_a1;
  logic [B_WIDTH-1:0] w_b1;

  assign w_in_d = {in_valid, m, a, b};

  dsp_pipe_reg #(.WIDTH(IN_W), .BYPASS(!HAS_IN)) u_stage_in (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (w_in_d),
    .q     (w_in_q)
  );

  assign {w_v1, w_m1, w_a1, w_b1} = w_in_q;

  // ---------------- product, extended to the accumulator width ----------------
  logic [PW-1:0]        w_prod_u;
  logic signed [PW-1:0] w_prod_s;
  logic [OUT_WIDTH-1:0] w_p;

  // Full-precision product, then sign- or zero-extension by operand type
  always_comb begin
    w_prod_u = PW'(w_a1) * PW'(w_b1);
    w_prod_s = $signed(PW'($signed(w_a1))) * $signed(PW'($signed(w_b1)));
    if (SIGNED != 0) begin
      w_p = OUT_WIDTH'(w_prod_s);
    end else begin
      w_p = OUT_WIDTH'(w_prod_u);
    end
  end

  // ---------------- MID stage: {valid, m, product} ----------------
  logic [MID_W-1:0]     w_mid_d;
  logic [MID_W-1:0]     w_mid_q;
  logic                 w_v2;
  logic                 w_m2;
  logic [OUT_WIDTH-1:0] w_p2;

  assign w_mid_d = {w_v1, w_m1, w_p};

  dsp_pipe_reg #(.WIDTH(MID_W), .BYPASS(!HAS_MID)) u_stage_mid (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (w_mid_d),
    .q     (w_mid_q)
  );

  assign {w_v2, w_m2, w_p2} = w_mid_q;

  // ---------------- accumulate point ----------------
  logic [OUT_WIDTH-1:0] acc_d;
  logic [OUT_WIDTH-1:0] acc_q;
  logic                 ovf_d;
  logic                 ovf_q;
  logic [OUT_WIDTH-1:0] w_acc_sel;
  logic [OUT_WIDTH:0]   w_sum;
  logic [OUT_WIDTH-1:0] w_s;
  logic                 w_add_ovf;

  // s = (m ? acc : 0) + p with wrap; overflow is carry-out or signed overflow
  always_comb begin
    w_acc_sel = w_m2 ? acc_q : '0;
    w_sum     = {1'b0, w_acc_sel} + {1'b0, w_p2};
    w_s       = w_sum[OUT_WIDTH-1:0];
    if (SIGNED != 0) begin
      w_add_ovf = (w_acc_sel[OUT_WIDTH-1] == w_p2[OUT_WIDTH-1]) &&
                  (w_s[OUT_WIDTH-1] != w_p2[OUT_WIDTH-1]);
    end else begin
      w_add_ovf = w_sum[OUT_WIDTH];
    end
    acc_d = w_s;
    ovf_d = w_m2 ? (ovf_q | w_add_ovf) : 1'b0;
  end

  // The accumulator and flag are always real state; they load only on valid data
  logic [OUT_WIDTH:0] w_acc_reg_d;
  logic [OUT_WIDTH:0] w_acc_reg_q;

  assign w_acc_reg_d = {ovf_d, acc_d};

  dsp_pipe_reg #(.WIDTH(OUT_WIDTH + 1), .BYPASS(1'b0)) u_stage_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce & w_v2),
    .d     (w_acc_reg_d),
    .q     (w_acc_reg_q)
  );

  assign {ovf_q, acc_q} = w_acc_reg_q;

  // ---------------- OUT stage valid ----------------
  logic w_v3;

  dsp_pipe_reg #(.WIDTH(1), .BYPASS(!HAS_OUT)) u_stage_out (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (w_v2),
    .q     (w_v3)
  );

  // Registered or combinational result; flag follows the same timing as out
  always_comb begin
    if (HAS_OUT) begin
      out = acc_q;
      ovf = rst_n & ovf_q;
    end else begin
      out = w_s;
      ovf = rst_n & (w_v2 ? ovf_d : ovf_q);
    end
    out_valid = rst_n & ce & w_v3;
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_modes.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_dsp_mac_modes                                                  |
// | Brief  : Bench for dsp_mac_modes over all modes, a narrow and a signed     |
// |          configuration, against a sample-level accumulator model          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_dsp_mac_modes;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       m;

  always #5 clk = ~clk;

  // Instance table: 0 NONE, 1 IN, 2 OUT, 3 INOUT, 4 PARTIAL, 5 FULL,
  // 6 INOUT with 4-bit result, 7 OUT signed
  localparam int LAT [8] = '{0, 1, 1, 2, 1, 3, 2, 1};
  localparam int WID [8] = '{8, 8, 8, 8, 8, 8, 4, 8};
  localparam int SGN [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  logic [7:0] o0, o1, o2, o3, o4, o5, o7;
  logic [3:0] o6;
  logic [7:0] v_l, f_l;
  logic [7:0] dout [8];
  logic       dval [8];
  logic       dovf [8];

  dsp_mac_modes #(.MODE("REGISTERED_NONE")) u0 (.clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .m(m), .out(o0), .out_valid(v_l[0]), .ovf(f_l[0]));
  dsp_mac_modes #(.MODE("REGISTERED_IN")) u1 (.clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .m(m), .out(o1), .out_valid(v_l[1]), .ovf(f_l[1]));
  dsp_mac_modes #(.MODE("REGISTERED_OUT")) u2 (.clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .m(m), .out(o2), .out_valid(v_l[2]), .ovf(f_l[2]));
  dsp_mac_modes #(.MODE("REGISTERED_INOUT")) u3 (.clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .m(m), .out(o3), .out_valid(v_l[3]), .ovf(f_l[3]));
  dsp_mac_modes #(.MODE("REGISTERED_PARTIAL")) u4 (.clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .m(m), .out(o4), .out_valid(v_l[4]), .ovf(f_l[4]));
  dsp_mac_modes #(.MODE("REGISTERED_FULL")) u5 (.clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .m(m), .out(o5), .out_valid(v_l[5]), .ovf(f_l[5]));
  dsp_mac_modes #(.OUT_WIDTH(4), .MODE("REGISTERED_INOUT")) u6 (.clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .a(a), .b(b), .m(m), .out(o6), .out_valid(v_l[6]), .ovf(f_l[6]));
  dsp_mac_modes #(.SIGNED(1), .MODE("REGISTERED_OUT")) u7 (.clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .a(a), .b(b), .m(m), .out(o7), .out_valid(v_l[7]), .ovf(f_l[7]));

  always_comb begin
    dout[0] = o0; dout[1] = o1; dout[2] = o2; dout[3] = o3;
    dout[4] = o4; dout[5] = o5; dout[6] = {4'b0000, o6}; dout[7] = o7;
    for (int i = 0; i < 8; i++) begin
      dval[i] = v_l[i];
      dovf[i] = f_l[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted sample yields one result, due once LAT further enabled edges pass.
  typedef struct {
    longint val;
    bit     ov;
    longint due;
  } item_t;

  item_t  pq [8][$];
  longint acc_m [8];
  bit     ovf_m [8];
  longint n_ce = 0;

  function automatic longint as_signed(input longint v, input int w);
    longint half;
    half = longint'(1) << (w - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  function automatic void model_accept(input int i, input int av, input int bv, input bit mv);
    longint modv, prod, sum, lo, hi;
    bit     ov;
    item_t  it;
    modv = longint'(1) << WID[i];
    if (SGN[i] != 0) prod = as_signed(longint'(av), 2) * as_signed(longint'(bv), 2);
    else             prod = longint'(av) * longint'(bv);
    ov = 1'b0;
    if (!mv) begin
      sum = prod;
      ovf_m[i] = 1'b0;
    end else if (SGN[i] != 0) begin
      sum = as_signed(acc_m[i], WID[i]) + prod;
      lo  = -(modv / 2);
      hi  = modv / 2 - 1;
      ov  = (sum < lo) || (sum > hi);
    end else begin
      sum = acc_m[i] + ((prod % modv) + modv) % modv;
      ov  = sum >= modv;
    end
    acc_m[i] = ((sum % modv) + modv) % modv;
    ovf_m[i] = ovf_m[i] | ov;
    it.val = acc_m[i];
    it.ov  = ovf_m[i];
    it.due = n_ce + longint'(LAT[i]);
    pq[i].push_back(it);
  endfunction

  // Compare every instance against the model in the middle of every cycle
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) begin
          pq[i].delete();
          acc_m[i] = 0;
          ovf_m[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (ce && in_valid) model_accept(i, int'(a), int'(b), m);
          exp_v = ce && (pq[i].size() > 0) && (pq[i][0].due == n_ce);
          chk($sformatf("model_valid[%0d]", i), longint'(dval[i]), longint'(exp_v));
          if (exp_v) begin
            chk($sformatf("model_out[%0d]", i), longint'(dout[i]), pq[i][0].val);
            chk($sformatf("model_ovf[%0d]", i), longint'(dovf[i]), longint'(pq[i][0].ov));
            void'(pq[i].pop_front());
          end
        end
        if (ce) n_ce++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input bit v, input int av, input int bv, input bit mv, input bit c);
    logic [31:0] ta, tb;
    ta = av;
    tb = bv;
    in_valid = v;
    a        = ta[1:0];
    b        = tb[1:0];
    m        = mv;
    ce       = c;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    put(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (n) begin
      @(negedge clk);
      next_cycle();
    end
  endtask

  task automatic expect_res(input string name, input int i, input longint val, input bit ov);
    chk({name, "_valid"}, longint'(dval[i]), 1);
    chk({name, "_out"}, longint'(dout[i]), val);
    chk({name, "_ovf"}, longint'(dovf[i]), longint'(ov));
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    rst_n = 1'b0;
    put(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) next_cycle();

    // Reset state: no valid, no flag, registered outputs cleared
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("reset_valid[%0d]", i), longint'(dval[i]), 0);
      chk($sformatf("reset_ovf[%0d]", i), longint'(dovf[i]), 0);
    end
    chk("reset_out_OUT", longint'(dout[2]), 0);
    chk("reset_out_INOUT", longint'(dout[3]), 0);
    chk("reset_out_FULL", longint'(dout[5]), 0);
    rst_n = 1'b1;
    put(1'b0, 0, 0, 1'b0, 1'b1);
    next_cycle();

    // NONE: combinational result in the same cycle
    put(1'b1, 3, 2, 1'b0, 1'b1);
    @(negedge clk);
    expect_res("none_3x2", 0, 6, 1'b0);
    next_cycle();
    idle(4);

    // INOUT: load then two accumulates, results on cycles 2..4
    put(1'b1, 3, 3, 1'b0, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 2, 1, 1'b1, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 1, 1, 1'b1, 1'b1); @(negedge clk);
    expect_res("inout_c2", 3, 9, 1'b0); next_cycle();
    put(1'b0, 0, 0, 1'b0, 1'b1); @(negedge clk);
    expect_res("inout_c3", 3, 11, 1'b0); next_cycle();
    @(negedge clk);
    expect_res("inout_c4", 3, 12, 1'b0); next_cycle();
    idle(4);

    // 4-bit INOUT: wrap with overflow, then a load clears the flag
    put(1'b1, 3, 3, 1'b0, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 3, 3, 1'b1, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 1, 1, 1'b0, 1'b1); @(negedge clk);
    expect_res("w4_load", 6, 9, 1'b0); next_cycle();
    put(1'b0, 0, 0, 1'b0, 1'b1); @(negedge clk);
    expect_res("w4_wrap", 6, 2, 1'b1);
    expect_res("w8_nowrap", 3, 18, 1'b0); next_cycle();
    @(negedge clk);
    expect_res("w4_clear", 6, 1, 1'b0); next_cycle();
    idle(4);

    // Signed OUT: -2*1 then accumulate (-2)*(-2)
    put(1'b1, 2, 1, 1'b0, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 2, 2, 1'b1, 1'b1); @(negedge clk);
    expect_res("signed_load", 7, 254, 1'b0); next_cycle();
    put(1'b0, 0, 0, 1'b0, 1'b1); @(negedge clk);
    expect_res("signed_acc", 7, 2, 1'b0); next_cycle();
    idle(4);

    // FULL: three in flight, two stall cycles, results slip by two cycles
    put(1'b1, 1, 1, 1'b0, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 2, 1, 1'b1, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 3, 1, 1'b1, 1'b1); @(negedge clk); next_cycle();
    put(1'b0, 0, 0, 1'b0, 1'b0); @(negedge clk);
    chk("full_stall1_valid", longint'(dval[5]), 0); next_cycle();
    @(negedge clk);
    chk("full_stall2_valid", longint'(dval[5]), 0); next_cycle();
    put(1'b0, 0, 0, 1'b0, 1'b1); @(negedge clk);
    expect_res("full_r0", 5, 1, 1'b0); next_cycle();
    @(negedge clk);
    expect_res("full_r1", 5, 3, 1'b0); next_cycle();
    @(negedge clk);
    expect_res("full_r2", 5, 6, 1'b0); next_cycle();
    idle(4);

    // Asynchronous reset in the middle of an accumulation
    put(1'b1, 1, 1, 1'b0, 1'b1); @(negedge clk); next_cycle();
    put(1'b1, 1, 1, 1'b1, 1'b1); @(negedge clk); next_cycle();
    put(1'b0, 0, 0, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", longint'(dout[3]), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("async_rst_valid[%0d]", i), longint'(dval[i]), 0);
      chk($sformatf("async_rst_ovf[%0d]", i), longint'(dovf[i]), 0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    next_cycle();
    put(1'b1, 2, 2, 1'b1, 1'b1); @(negedge clk); next_cycle();
    put(1'b0, 0, 0, 1'b0, 1'b1); @(negedge clk); next_cycle();
    @(negedge clk);
    expect_res("post_rst_acc", 3, 4, 1'b0); next_cycle();
    idle(2);

    // Random traffic with stalls, loads and long accumulations
    for (int n = 0; n < 3000; n++) begin
      put($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 6) != 0);
      @(negedge clk);
      next_cycle();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
